// File: rtl/peripheral_adder_pkg.sv
// Shared types and defaults for the peripheral adder arbiter: in-flight tag layout,
// default widths, and the round-robin pointer wrap helper.
package peripheral_adder_pkg;

   localparam int NUM_REQ_DEF      = 4;
   localparam int DATA_WIDTH_DEF   = 32;
   localparam int RESULT_WIDTH_DEF = DATA_WIDTH_DEF + 1;

   // Tag index is sized for the largest supported requester count (16).
   localparam int TAG_IDX_W = $clog2(16);

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

   function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/peripheral_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N, reported as one-hot grant plus its index.
module peripheral_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          grant_vld_o
);

   logic [IW:0]   sum;
   logic [IW-1:0] cand;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      sum         = '0;
      cand        = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_i} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         cand = sum[IW-1:0];
         if (!grant_vld_o && req_i[cand]) begin
            grant_vld_o   = 1'b1;
            grant_o[cand] = 1'b1;
            grant_idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/peripheral_adder_arbiter.sv
// Shares one external registered adder between NUM_REQ requesters: round-robin
// grant, operand registers, in-flight tag pipeline and per-requester response holding.
module peripheral_adder_arbiter
   import peripheral_adder_pkg::*;
#(
   parameter int NUM_REQ       = NUM_REQ_DEF,
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDER_LATENCY = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_in1,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_in2,
   output logic [NUM_REQ-1:0]                rsp_valid,
   input  logic [NUM_REQ-1:0]                rsp_ready,
   output logic [NUM_REQ*(DATA_WIDTH+1)-1:0] rsp_data,
   output logic [DATA_WIDTH-1:0]             adder_in1,
   output logic [DATA_WIDTH-1:0]             adder_in2,
   input  logic [DATA_WIDTH:0]               adder_out,
   output logic                              busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int RW = DATA_WIDTH + 1;

   logic [DATA_WIDTH-1:0] in1_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0] in2_arr [NUM_REQ];

   logic [NUM_REQ-1:0] slot_busy_q, slot_busy_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [RW-1:0]      rsp_data_q [NUM_REQ];
   logic [RW-1:0]      rsp_data_d [NUM_REQ];
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] ain1_q, ain1_d, ain2_q, ain2_d;
   tag_t               tag_q [ADDER_LATENCY+1];
   tag_t               tag_end;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic               grant_vld;
   logic               hs;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign in1_arr[gi]               = req_in1[gi*DATA_WIDTH +: DATA_WIDTH];
         assign in2_arr[gi]               = req_in2[gi*DATA_WIDTH +: DATA_WIDTH];
         assign rsp_data[gi*RW +: RW]     = rsp_data_q[gi];
      end
   endgenerate

   // A requester with an unaccepted result stays out of arbitration.
   assign eligible = req_valid & ~slot_busy_q;

   peripheral_rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_arbiter (
      .req_i       (eligible),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_vld_o (grant_vld)
   );

   assign hs        = grant_vld & rst;
   assign req_ready = rst ? grant : '0;
   assign tag_end   = tag_q[ADDER_LATENCY];

   always_comb begin
      slot_busy_d = slot_busy_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      ptr_d       = ptr_q;
      ain1_d      = ain1_q;
      ain2_d      = ain2_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rsp_valid_q[i] && rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
            slot_busy_d[i] = 1'b0;
         end
         if (tag_end.valid && (tag_end.idx == TAG_IDX_W'(i))) begin
            rsp_valid_d[i] = 1'b1;
            rsp_data_d[i]  = adder_out;
         end
      end
      if (hs) begin
         slot_busy_d[grant_idx] = 1'b1;
         ptr_d  = IW'(rr_wrap_inc(32'(grant_idx), unsigned'(NUM_REQ)));
         ain1_d = in1_arr[grant_idx];
         ain2_d = in2_arr[grant_idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_busy_q <= '0;
         rsp_valid_q <= '0;
         ptr_q       <= '0;
         ain1_q      <= '0;
         ain2_q      <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data_q[i] <= '0;
         end
         for (int k = 0; k <= ADDER_LATENCY; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         slot_busy_q <= slot_busy_d;
         rsp_valid_q <= rsp_valid_d;
         ptr_q       <= ptr_d;
         ain1_q      <= ain1_d;
         ain2_q      <= ain2_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data_q[i] <= rsp_data_d[i];
         end
         // Stage 0 launches with the operands; the last stage lines up with adder_out.
         tag_q[0] <= '{valid: hs, idx: TAG_IDX_W'(grant_idx)};
         for (int k = 1; k <= ADDER_LATENCY; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign adder_in1 = ain1_q;
   assign adder_in2 = ain2_q;
   assign busy      = |slot_busy_q;

endmodule

// File: tb/tb_peripheral_adder_arbiter.sv
// Bench for peripheral_adder_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of slots, grants and response timing.
module tb_peripheral_adder_arbiter;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int LAT = 1;
   localparam int RW  = DW + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_in1 = '0;
   logic [N*DW-1:0] req_in2 = '0;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '0;
   logic [N*RW-1:0] rsp_data;
   logic [DW-1:0]   adder_in1, adder_in2;
   logic [RW-1:0]   adder_out;
   logic            busy;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: per-requester slot state and countdown to result visibility.
   int            m_ptr;
   bit            m_busy [N];
   bit            m_vis  [N];
   int            m_cnt  [N];
   logic [RW-1:0] m_sum  [N];
   logic [DW-1:0] m_ain1, m_ain2;
   logic [N-1:0]  exp_grant;

   always #5 clk = ~clk;

   // External adder with one register stage.
   always @(posedge clk) adder_out <= {1'b0, adder_in1} + {1'b0, adder_in2};

   peripheral_adder_arbiter #(
      .NUM_REQ       (N),
      .DATA_WIDTH    (DW),
      .ADDER_LATENCY (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .adder_in1 (adder_in1),
      .adder_in2 (adder_in2),
      .adder_out (adder_out),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [N*RW-1:0] obs, input logic [N*RW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic mdl_reset();
      m_ptr  = 0;
      m_ain1 = '0;
      m_ain2 = '0;
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0;
         m_vis[i]  = 1'b0;
         m_cnt[i]  = 0;
         m_sum[i]  = '0;
      end
   endtask

   function automatic logic [N-1:0] mdl_grant();
      logic [N-1:0] g;
      int c;
      g = '0;
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (req_valid[c] && !m_busy[c]) begin
               g[c] = 1'b1;
               break;
            end
         end
      end
      return g;
   endfunction

   task automatic mdl_edge();
      for (int i = 0; i < N; i++) begin
         if (m_vis[i] && rsp_ready[i]) begin
            m_vis[i]  = 1'b0;
            m_busy[i] = 1'b0;
         end else if (m_cnt[i] > 0) begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) m_vis[i] = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (exp_grant[i]) begin
            m_busy[i] = 1'b1;
            m_cnt[i]  = LAT + 1;
            m_sum[i]  = {1'b0, req_in1[i*DW +: DW]} + {1'b0, req_in2[i*DW +: DW]};
            m_ain1    = req_in1[i*DW +: DW];
            m_ain2    = req_in2[i*DW +: DW];
            m_ptr     = (i + 1) % N;
         end
      end
   endtask

   // One clock cycle: compare outputs to the model, then advance both across the edge.
   task automatic step();
      logic [N-1:0] vis_v, busy_v;
      #1;
      if (!rst) mdl_reset();
      exp_grant = mdl_grant();
      for (int i = 0; i < N; i++) begin
         vis_v[i]  = m_vis[i];
         busy_v[i] = m_busy[i];
      end
      check("req_ready", req_ready, exp_grant);
      check("rsp_valid", rsp_valid, vis_v);
      check("busy", busy, |busy_v);
      check("adder_in1", adder_in1, m_ain1);
      check("adder_in2", adder_in2, m_ain2);
      for (int i = 0; i < N; i++) begin
         if (m_vis[i]) check($sformatf("rsp_data%0d", i), rsp_data[i*RW +: RW], m_sum[i]);
      end
      @(posedge clk);
      if (rst) mdl_edge();
      @(negedge clk);
   endtask

   task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_in1[i*DW +: DW] = a;
      req_in2[i*DW +: DW] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(7) == 0) set_ops(i, 32'hFFFF_FFFF, $urandom);
         else set_ops(i, $urandom, $urandom);
      end
   endtask

   initial begin
      logic [N-1:0] one_hot;
      int cnt1;
      mdl_reset();
      rand_ops();

      // Reset holds everything quiet even with every request raised.
      rst = 1'b0;
      req_valid = '1;
      @(negedge clk);
      #1;
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_data", rsp_data, '0);
      check("rst_adder_in1", adder_in1, '0);
      check("rst_busy", busy, 1'b0);
      step();
      step();

      // Single op 5 + 7, result held until accepted.
      rst = 1'b1;
      req_valid = '0;
      step();
      set_ops(0, 32'd5, 32'd7);
      req_valid = 4'b0001;
      #1 check("t2_grant", req_ready, 4'b0001);
      step();
      req_valid = '0;
      step();
      #1 check("t2_not_yet", rsp_valid, '0);
      step();
      #1 check("t2_rsp_valid", rsp_valid, 4'b0001);
      check("t2_rsp_data", rsp_data[0 +: RW], 33'd12);
      step();
      step();
      step();
      #1 check("t2_held_valid", rsp_valid, 4'b0001);
      check("t2_held_data", rsp_data[0 +: RW], 33'd12);
      rsp_ready = 4'b0001;
      step();
      rsp_ready = '0;
      #1 check("t2_accepted", rsp_valid, '0);
      check("t2_idle", busy, 1'b0);

      // Carry out of the top bit is kept.
      set_ops(0, 32'hFFFF_FFFF, 32'd1);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      step();
      step();
      #1 check("t3_carry", rsp_data[0 +: RW], 33'h1_0000_0000);
      rsp_ready = 4'b0001;
      step();
      rsp_ready = '0;

      // Continuous round-robin with every requester consuming results at once.
      rst = 1'b0;
      step();
      rst = 1'b1;
      req_valid = '1;
      rsp_ready = '1;
      for (int k = 0; k < 12; k++) begin
         one_hot = 4'b0001 << (k % 4);
         #1 check($sformatf("t4_rr%0d", k), req_ready, one_hot);
         rand_ops();
         step();
      end

      // Requester 1 withholds its accept and must not be granted again.
      rst = 1'b0;
      step();
      rst = 1'b1;
      req_valid = '1;
      rsp_ready = 4'b1101;
      cnt1 = 0;
      for (int k = 0; k < 16; k++) begin
         #1 if (req_ready[1]) cnt1++;
         rand_ops();
         step();
      end
      check("t5_req1_grants", cnt1, 1);
      req_valid = 4'b0010;
      rsp_ready = 4'b1111;
      #1 check("t5_no_regrant", req_ready, '0);
      step();
      #1 check("t5_regrant", req_ready, 4'b0010);
      step();

      // Reset while an op is in flight discards it.
      rst = 1'b0;
      step();
      rst = 1'b1;
      rsp_ready = '0;
      req_valid = 4'b0100;
      #1 check("t6_grant", req_ready, 4'b0100);
      step();
      req_valid = '0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1 check("t6_no_rsp", rsp_valid, '0);
         check("t6_busy", busy, 1'b0);
         step();
      end

      // Random traffic with occasional reset pulses.
      for (int k = 0; k < 400; k++) begin
         req_valid = N'($urandom);
         rsp_ready = N'($urandom) | N'($urandom);
         rand_ops();
         rst = ($urandom_range(99) != 0);
         step();
      end
      rst = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
